// File: rtl/mealy_seq_detect.sv
// Run-time programmable serial pattern detector with a registered match pulse
// and a saturating match counter. Overlapping and non-overlapping modes are supported.
module mealy_seq_detect #(
  parameter int               PAT_W       = 8,
  parameter int               CNT_W       = 8,
  parameter logic [PAT_W-1:0] DEF_PATTERN = 'b101,
  parameter int               DEF_LEN     = 3,
  parameter bit               DEF_OVERLAP = 1'b0,
  localparam int              LEN_W       = $clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             R,
  input  logic             en,
  input  logic             in,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_overlap,
  input  logic             clr_count,
  output logic             out,
  output logic [CNT_W-1:0] match_count,
  output logic [LEN_W-1:0] fill
);

  typedef enum logic [1:0] {EMPTY, FILLING, ARMED} det_state_t;

  // Lengths outside 1..PAT_W are pulled back into range rather than rejected.
  function automatic logic [LEN_W-1:0] clamp_len(input int l);
    if (l < 1)          return LEN_W'(1);
    else if (l > PAT_W) return LEN_W'(PAT_W);
    else                return LEN_W'(l);
  endfunction

  localparam logic [LEN_W-1:0] RST_LEN = clamp_len(DEF_LEN);

  logic [PAT_W-1:0] pat, pat_n;
  logic [LEN_W-1:0] len, len_n;
  logic             ovl, ovl_n;
  logic [PAT_W-1:0] hist, hist_n;
  logic [LEN_W-1:0] fill_n;
  logic             out_n;
  logic [CNT_W-1:0] cnt_n;

  det_state_t       state;
  logic [PAT_W-1:0] hist_shift;
  logic [PAT_W-1:0] mask;
  logic [LEN_W-1:0] fill_inc;
  logic             hit;

  always_ff @(posedge clk or posedge R) begin
    if (R) begin
      pat         <= DEF_PATTERN;
      len         <= RST_LEN;
      ovl         <= DEF_OVERLAP;
      hist        <= '0;
      fill        <= '0;
      out         <= 1'b0;
      match_count <= '0;
    end else begin
      pat         <= pat_n;
      len         <= len_n;
      ovl         <= ovl_n;
      hist        <= hist_n;
      fill        <= fill_n;
      out         <= out_n;
      match_count <= cnt_n;
    end
  end

  // The fill counter doubles as the detector state; a hit is only possible
  // once the incoming bit brings the history up to a full pattern length.
  always_comb begin
    pat_n      = pat;
    len_n      = len;
    ovl_n      = ovl;
    hist_n     = hist;
    fill_n     = fill;
    out_n      = 1'b0;
    cnt_n      = match_count;
    hist_shift = {hist[PAT_W-2:0], in};
    mask       = ~({PAT_W{1'b1}} << len);

    if (fill == '0)       state = EMPTY;
    else if (fill == len) state = ARMED;
    else                  state = FILLING;

    fill_inc = (state == ARMED) ? len : fill + 1'b1;
    hit      = (fill_inc == len) && (((hist_shift ^ pat) & mask) == '0);

    if (cfg_load) begin
      pat_n  = cfg_pattern;
      len_n  = clamp_len(int'(cfg_len));
      ovl_n  = cfg_overlap;
      hist_n = '0;
      fill_n = '0;
    end else if (en) begin
      hist_n = hist_shift;
      if (hit) begin
        out_n  = 1'b1;
        cnt_n  = (match_count == {CNT_W{1'b1}}) ? match_count : match_count + 1'b1;
        fill_n = ovl ? len : '0;
      end else begin
        fill_n = fill_inc;
      end
    end

    if (clr_count) cnt_n = '0;
  end

endmodule

// File: tb/tb_mealy_seq_detect.sv
// Randomised and directed bench for mealy_seq_detect, checked against a
// bit-queue reference model of the detector.
module tb_mealy_seq_detect;

  localparam int PAT_W   = 8;
  localparam int CNT_W   = 8;
  localparam int LEN_W   = $clog2(PAT_W + 1);
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             R = 1'b1;
  logic             en = 1'b0;
  logic             in = 1'b0;
  logic             cfg_load = 1'b0;
  logic [PAT_W-1:0] cfg_pattern = '0;
  logic [LEN_W-1:0] cfg_len = '0;
  logic             cfg_overlap = 1'b0;
  logic             clr_count = 1'b0;
  logic             out;
  logic [CNT_W-1:0] match_count;
  logic [LEN_W-1:0] fill;

  int errors = 0;
  int checks = 0;

  // Reference model: received bits since the last restart, plus configuration.
  bit         q[$];
  logic [7:0] mPat;
  int         mLen;
  bit         mOvl;
  bit         mOut;
  int         mCnt;

  mealy_seq_detect #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .R(R), .en(en), .in(in), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .clr_count(clr_count), .out(out), .match_count(match_count), .fill(fill)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic int clampLen(input int l);
    if (l < 1) return 1;
    if (l > PAT_W) return PAT_W;
    return l;
  endfunction

  task automatic modelReset();
    q.delete();
    mPat = 8'b101;
    mLen = 3;
    mOvl = 1'b0;
    mOut = 1'b0;
    mCnt = 0;
  endtask

  task automatic modelStep(input bit e, input bit b, input bit ld, input logic [7:0] p,
                           input int l, input bit o, input bit clr);
    bit hit;
    mOut = 1'b0;
    if (ld) begin
      mPat = p;
      mLen = clampLen(l);
      mOvl = o;
      q.delete();
    end else if (e) begin
      q.push_back(b);
      if (q.size() > PAT_W) void'(q.pop_front());
      hit = (q.size() >= mLen);
      if (hit)
        for (int i = 0; i < mLen; i++)
          if (q[q.size() - 1 - i] != mPat[i]) hit = 1'b0;
      if (hit) begin
        mOut = 1'b1;
        if (mCnt < CNT_MAX) mCnt++;
        if (!mOvl) q.delete();
      end
    end
    if (clr) mCnt = 0;
  endtask

  task automatic compareAll(input string tag);
    int expFill;
    expFill = (q.size() < mLen) ? q.size() : mLen;
    checkOutput({tag, "_out"}, int'(out), int'(mOut));
    checkOutput({tag, "_count"}, int'(match_count), mCnt);
    checkOutput({tag, "_fill"}, int'(fill), expFill);
  endtask

  task automatic applyStimulus(input bit e, input bit b, input bit ld, input logic [7:0] p,
                               input int l, input bit o, input bit clr, input string tag);
    en          = e;
    in          = b;
    cfg_load    = ld;
    cfg_pattern = p;
    cfg_len     = LEN_W'(l);
    cfg_overlap = o;
    clr_count   = clr;
    @(posedge clk);
    modelStep(e, b, ld, p, l, o, clr);
    #1;
    compareAll(tag);
  endtask

  task automatic sendBit(input bit b, input string tag);
    applyStimulus(1'b1, b, 1'b0, 8'h00, 0, 1'b0, 1'b0, tag);
  endtask

  task automatic idle(input string tag);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b0, tag);
  endtask

  task automatic loadCfg(input logic [7:0] p, input int l, input bit o, input bit e, input string tag);
    applyStimulus(e, 1'b1, 1'b1, p, l, o, 1'b0, tag);
  endtask

  // Reset is raised between clock edges and must clear outputs immediately.
  task automatic asyncReset(input string tag);
    #2;
    R = 1'b1;
    modelReset();
    #1;
    compareAll(tag);
    @(negedge clk);
    R = 1'b0;
  endtask

  initial begin
    modelReset();
    #12;
    compareAll("reset");
    @(negedge clk);
    R = 1'b0;

    // Default non-overlapping 101
    sendBit(1, "def"); sendBit(0, "def"); sendBit(1, "def");
    checkOutput("def_third_pulse", int'(out), 1);
    sendBit(0, "def"); sendBit(1, "def");
    checkOutput("def_no_fifth", int'(out), 0);
    checkOutput("def_count1", int'(match_count), 1);

    // Overlapping 101
    loadCfg(8'b101, 3, 1'b1, 1'b0, "ovl_cfg");
    sendBit(1, "ovl"); sendBit(0, "ovl"); sendBit(1, "ovl");
    sendBit(0, "ovl"); sendBit(1, "ovl");
    checkOutput("ovl_fifth_pulse", int'(out), 1);
    checkOutput("ovl_count3", int'(match_count), 3);

    // 1101 with en gaps
    loadCfg(8'b1101, 4, 1'b0, 1'b0, "gap_cfg");
    foreach (q[i]) ;
    sendBit(1, "gap"); idle("gap"); idle("gap");
    sendBit(1, "gap"); idle("gap"); idle("gap");
    sendBit(0, "gap"); idle("gap"); idle("gap");
    sendBit(1, "gap");
    checkOutput("gap_pulse", int'(out), 1);
    idle("gap");
    checkOutput("gap_single", int'(out), 0);

    // Single-bit pattern, saturation, then clear with a hit
    loadCfg(8'b1, 1, 1'b1, 1'b0, "sat_cfg");
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b1, "sat_clr");
    for (int i = 0; i < CNT_MAX + 5; i++) sendBit(1, "sat");
    checkOutput("sat_count", int'(match_count), CNT_MAX);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00, 0, 1'b0, 1'b1, "clr_hit");
    checkOutput("clr_hit_out", int'(out), 1);
    checkOutput("clr_hit_count", int'(match_count), 0);

    // Mid-stream asynchronous reset
    sendBit(1, "pre_rst"); sendBit(0, "pre_rst");
    asyncReset("mid_rst");
    sendBit(1, "post_rst");
    checkOutput("post_rst_nopulse", int'(out), 0);
    sendBit(0, "post_rst"); sendBit(1, "post_rst");
    checkOutput("post_rst_pulse", int'(out), 1);

    // Length clamping and load with en on the same edge
    loadCfg(8'b0, 0, 1'b0, 1'b0, "len0_cfg");
    sendBit(0, "len0");
    checkOutput("len0_pulse", int'(out), 1);
    loadCfg(8'hA5, 15, 1'b0, 1'b1, "len15_cfg");
    checkOutput("load_en_fill", int'(fill), 0);
    for (int i = 7; i >= 0; i--) begin
      logic [7:0] pv;
      pv = 8'hA5;
      sendBit(pv[i], "len15");
      if (i > 0) checkOutput("len15_early", int'(out), 0);
    end
    checkOutput("len15_pulse", int'(out), 1);

    // Randomised traffic
    for (int n = 0; n < 3000; n++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 3) begin
        loadCfg(8'($urandom), $urandom_range(0, 15), 1'($urandom), 1'($urandom), "rnd_cfg");
      end else if (r < 4) begin
        asyncReset("rnd_rst");
      end else begin
        applyStimulus(($urandom_range(0, 3) != 0), 1'($urandom), 1'b0, 8'h00, 0, 1'b0,
                      ($urandom_range(0, 49) == 0), "rnd");
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
